// File: rtl/dm_arbiter_pkg.sv
// Shared encodings and constants for the data-memory arbiter slice.
package dm_arbiter_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    DMA_LOCK = 1'b1
  } arbState_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Word alignment: the DM ignores byte-offset bits [1:0].
  localparam logic [63:0] ADDR_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/dm_resp_pipe.sv
// Read-response tag pipe: MEM_LAT-deep {valid, owner} shift register that
// steers the exiting tag to the owning port's rvalid/rdata.
module dm_resp_pipe
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inValid,
  input  owner_t        inOwner,
  input  logic [DW-1:0] memRdata,
  output logic          cpuRvalid,
  output logic [DW-1:0] cpuRdata,
  output logic          dmaRvalid,
  output logic [DW-1:0] dmaRdata,
  output logic          anyValid
);

  logic [MEM_LAT-1:0] tagValid;
  owner_t             tagOwner [MEM_LAT];
  logic [DW-1:0]      cpuHold;
  logic [DW-1:0]      dmaHold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagValid <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) tagOwner[i] <= OWN_CPU;
      cpuHold <= '0;
      dmaHold <= '0;
    end else begin
      tagValid[0] <= inValid;
      tagOwner[0] <= inOwner;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagOwner[i] <= tagOwner[i-1];
      end
      if (cpuRvalid) cpuHold <= memRdata;
      if (dmaRvalid) dmaHold <= memRdata;
    end
  end

  // The exiting tag lines up with the cycle in which mem_rdata is valid.
  assign cpuRvalid = tagValid[MEM_LAT-1] && (tagOwner[MEM_LAT-1] == OWN_CPU);
  assign dmaRvalid = tagValid[MEM_LAT-1] && (tagOwner[MEM_LAT-1] == OWN_DMA);
  assign cpuRdata  = cpuRvalid ? memRdata : cpuHold;
  assign dmaRdata  = dmaRvalid ? memRdata : dmaHold;
  assign anyValid  = |tagValid;

endmodule

// File: rtl/dm_arbiter.sv
// Single-port DM arbiter: cpu priority with dma starvation guard, dma burst
// locking with beat limit, and in-order read return after MEM_LAT cycles.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_last,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arbState_t     state;
  logic [SW-1:0] starveCnt;
  logic [BW-1:0] beatCnt;
  logic          starveHit;
  logic          tagsValid;
  logic [AW-1:0] selAddr;

  assign starveHit = (starveCnt == SW'(STARVE_MAX));

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset) begin
      if (state == DMA_LOCK) begin
        dma_gnt = dma_req;
      end else begin
        dma_gnt = dma_req && (!cpu_req || starveHit);
        cpu_gnt = cpu_req && !dma_gnt;
      end
    end
  end

  assign mem_en    = cpu_gnt || dma_gnt;
  assign mem_we    = dma_gnt ? dma_we : (cpu_gnt && cpu_we);
  assign selAddr   = dma_gnt ? dma_addr : cpu_addr;
  assign mem_addr  = selAddr & ADDR_ALIGN_MASK[AW-1:0];
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      starveCnt <= '0;
      beatCnt   <= '0;
    end else begin
      if (dma_gnt || !dma_req) starveCnt <= '0;
      else if (state == ARB && !starveHit) starveCnt <= starveCnt + SW'(1);

      case (state)
        ARB: begin
          // A single-beat limit never needs the lock.
          if (dma_gnt && !dma_last && MAX_BURST > 1) begin
            state   <= DMA_LOCK;
            beatCnt <= BW'(1);
          end
        end
        DMA_LOCK: begin
          if (dma_gnt) begin
            if (dma_last || (beatCnt + BW'(1) == BW'(MAX_BURST))) begin
              state   <= ARB;
              beatCnt <= '0;
            end else begin
              beatCnt <= beatCnt + BW'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  dm_resp_pipe #(
    .DW      (DW),
    .MEM_LAT (MEM_LAT)
  ) u_respPipe (
    .clk       (clk),
    .reset     (reset),
    .inValid   (mem_en && !mem_we),
    .inOwner   (dma_gnt ? OWN_DMA : OWN_CPU),
    .memRdata  (mem_rdata),
    .cpuRvalid (cpu_rvalid),
    .cpuRdata  (cpu_rdata),
    .dmaRvalid (dma_rvalid),
    .dmaRdata  (dma_rdata),
    .anyValid  (tagsValid)
  );

  assign busy = (state == DMA_LOCK) || tagsValid;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// sharing all inputs.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic        cpu_gnt1, cpu_rvalid1, dma_gnt1, dma_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
  logic        cpu_gnt3, cpu_rvalid3, dma_gnt3, dma_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] cpu_rdata3, dma_rdata3, mem_addr3, mem_wdata3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4), .MAX_BURST(8)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  dm_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4), .MAX_BURST(8)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt3), .dma_rvalid(dma_rvalid3), .dma_rdata(dma_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata), .busy(busy3)
  );

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      nextCycle();
      cpu_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_gnt1 !== 1'b0) begin failures++; $display("FAIL rst_cpu_gnt got=%b exp=0", cpu_gnt1); end
    checks++; if (dma_gnt1 !== 1'b0) begin failures++; $display("FAIL rst_dma_gnt got=%b exp=0", dma_gnt1); end
    checks++; if (mem_en1 !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en1); end
    checks++; if (cpu_rvalid1 !== 1'b0 || dma_rvalid1 !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", cpu_rvalid1, dma_rvalid1); end
    checks++; if (cpu_rdata1 !== 32'h0 || dma_rdata1 !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", cpu_rdata1, dma_rdata1); end
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b%b exp=00", busy1, busy3); end
    nextCycle();
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_cpu_load;
    nextCycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0013;
    @(negedge clk);
    checks++; if (cpu_gnt1 !== 1'b1) begin failures++; $display("FAIL load_gnt got=%b exp=1", cpu_gnt1); end
    checks++; if (dma_gnt1 !== 1'b0) begin failures++; $display("FAIL load_dma_gnt got=%b exp=0", dma_gnt1); end
    checks++; if (mem_en1 !== 1'b1 || mem_we1 !== 1'b0) begin failures++; $display("FAIL load_mem_en_we got=%b%b exp=10", mem_en1, mem_we1); end
    checks++; if (mem_addr1 !== 32'h0000_0010) begin failures++; $display("FAIL load_addr got=%h exp=00000010", mem_addr1); end
    nextCycle();
    cpu_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (cpu_rvalid1 !== 1'b1) begin failures++; $display("FAIL load_rvalid got=%b exp=1", cpu_rvalid1); end
    checks++; if (cpu_rdata1 !== 32'hCAFE_0001) begin failures++; $display("FAIL load_rdata got=%h exp=cafe0001", cpu_rdata1); end
    checks++; if (dma_rvalid1 !== 1'b0) begin failures++; $display("FAIL load_dma_rvalid got=%b exp=0", dma_rvalid1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy1); end
    nextCycle();
    mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (cpu_rvalid1 !== 1'b0) begin failures++; $display("FAIL load_rvalid_pulse got=%b exp=0", cpu_rvalid1); end
    checks++; if (cpu_rdata1 !== 32'hCAFE_0001) begin failures++; $display("FAIL load_rdata_hold got=%h exp=cafe0001", cpu_rdata1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL load_busy_clear got=%b exp=0", busy1); end
    idle(4);
  endtask

  task automatic test_cpu_store;
    nextCycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0022; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (cpu_gnt1 !== 1'b1 || mem_we1 !== 1'b1) begin failures++; $display("FAIL store_gnt_we got=%b%b exp=11", cpu_gnt1, mem_we1); end
    checks++; if (mem_addr1 !== 32'h0000_0020) begin failures++; $display("FAIL store_addr got=%h exp=00000020", mem_addr1); end
    checks++; if (mem_wdata1 !== 32'h1234_5678) begin failures++; $display("FAIL store_wdata got=%h exp=12345678", mem_wdata1); end
    nextCycle();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (cpu_rvalid1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL store_no_resp got=%b%b exp=00", cpu_rvalid1, busy1); end
    idle(1);
  endtask

  task automatic test_starvation;
    logic expD;
    cpu_we = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0107; dma_wdata = 32'hD0D0_0001;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      cpu_req = 1'b1; dma_req = 1'b1; dma_last = 1'b1;
      @(negedge clk);
      expD = ((i % 5) == 4);
      checks++; if (dma_gnt1 !== expD) begin failures++; $display("FAIL starve_dma_gnt c%0d got=%b exp=%b", i, dma_gnt1, expD); end
      checks++; if (cpu_gnt1 !== !expD) begin failures++; $display("FAIL starve_cpu_gnt c%0d got=%b exp=%b", i, cpu_gnt1, !expD); end
      if (expD) begin
        checks++; if (mem_addr1 !== 32'h0000_0104 || mem_wdata1 !== 32'hD0D0_0001) begin failures++; $display("FAIL starve_dma_mem c%0d got=%h/%h exp=00000104/d0d00001", i, mem_addr1, mem_wdata1); end
      end
    end
    idle(1);
  endtask

  task automatic test_burst3;
    logic expD, expBusy;
    cpu_we = 1'b1; dma_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      cpu_req = 1'b1; dma_req = (i < 7); dma_last = (i == 6);
      @(negedge clk);
      expD = (i >= 4 && i <= 6);
      expBusy = (i == 5 || i == 6);
      checks++; if (dma_gnt1 !== expD) begin failures++; $display("FAIL burst3_dma_gnt c%0d got=%b exp=%b", i, dma_gnt1, expD); end
      checks++; if (cpu_gnt1 !== !expD) begin failures++; $display("FAIL burst3_cpu_gnt c%0d got=%b exp=%b", i, cpu_gnt1, !expD); end
      checks++; if (busy1 !== expBusy) begin failures++; $display("FAIL burst3_busy c%0d got=%b exp=%b", i, busy1, expBusy); end
    end
    idle(1);
  endtask

  task automatic test_max_burst;
    logic expD, expC, expBusy;
    cpu_we = 1'b1; dma_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      cpu_req = (i != 0); dma_req = (i != 3 && i < 15); dma_last = (i == 14);
      @(negedge clk);
      expD = (i <= 2) || (i >= 4 && i <= 8) || (i == 13) || (i == 14);
      expC = (i >= 9 && i <= 12) || (i == 15);
      expBusy = (i >= 1 && i <= 8) || (i == 14);
      checks++; if (dma_gnt1 !== expD) begin failures++; $display("FAIL maxb_dma_gnt c%0d got=%b exp=%b", i, dma_gnt1, expD); end
      checks++; if (cpu_gnt1 !== expC) begin failures++; $display("FAIL maxb_cpu_gnt c%0d got=%b exp=%b", i, cpu_gnt1, expC); end
      checks++; if (mem_en1 !== (expC || expD)) begin failures++; $display("FAIL maxb_mem_en c%0d got=%b exp=%b", i, mem_en1, expC || expD); end
      checks++; if (busy1 !== expBusy) begin failures++; $display("FAIL maxb_busy c%0d got=%b exp=%b", i, busy1, expBusy); end
    end
    idle(1);
  endtask

  task automatic test_latency;
    logic expC, expD, expBusy;
    logic [31:0] expData;
    cpu_we = 1'b0; dma_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      cpu_req = (i == 0 || i == 2); dma_req = (i == 1 || i == 3); dma_last = 1'b1;
      cpu_addr = 32'h40 + 32'(i) * 4; dma_addr = 32'h80 + 32'(i) * 4;
      mem_rdata = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      expC = (i == 3 || i == 5);
      expD = (i == 4 || i == 6);
      expBusy = (i >= 1 && i <= 6);
      expData = 32'hD000_0000 + 32'(i);
      checks++; if (cpu_gnt3 !== cpu_req || dma_gnt3 !== dma_req) begin failures++; $display("FAIL lat_gnt c%0d got=%b%b exp=%b%b", i, cpu_gnt3, dma_gnt3, cpu_req, dma_req); end
      checks++; if (cpu_rvalid3 !== expC) begin failures++; $display("FAIL lat_cpu_rvalid c%0d got=%b exp=%b", i, cpu_rvalid3, expC); end
      checks++; if (dma_rvalid3 !== expD) begin failures++; $display("FAIL lat_dma_rvalid c%0d got=%b exp=%b", i, dma_rvalid3, expD); end
      checks++; if (busy3 !== expBusy) begin failures++; $display("FAIL lat_busy c%0d got=%b exp=%b", i, busy3, expBusy); end
      if (expC) begin
        checks++; if (cpu_rdata3 !== expData) begin failures++; $display("FAIL lat_cpu_rdata c%0d got=%h exp=%h", i, cpu_rdata3, expData); end
      end
      if (expD) begin
        checks++; if (dma_rdata3 !== expData) begin failures++; $display("FAIL lat_dma_rdata c%0d got=%h exp=%h", i, dma_rdata3, expData); end
      end
    end
    checks++; if (cpu_rdata3 !== 32'hD000_0005) begin failures++; $display("FAIL lat_cpu_hold got=%h exp=d0000005", cpu_rdata3); end
    checks++; if (dma_rdata3 !== 32'hD000_0006) begin failures++; $display("FAIL lat_dma_hold got=%h exp=d0000006", dma_rdata3); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    cpu_we = 1'b0; dma_we = 1'b0;
    nextCycle();
    cpu_req = 1'b0; dma_req = 1'b1; dma_last = 1'b0;
    @(negedge clk);
    checks++; if (dma_gnt3 !== 1'b1) begin failures++; $display("FAIL rmid_beat1 got=%b exp=1", dma_gnt3); end
    nextCycle();
    @(negedge clk);
    checks++; if (dma_gnt3 !== 1'b1 || busy3 !== 1'b1) begin failures++; $display("FAIL rmid_beat2 got=%b%b exp=11", dma_gnt3, busy3); end
    nextCycle();
    reset = 1'b0;
    #1;
    checks++; if (cpu_rvalid3 !== 1'b0 || dma_rvalid3 !== 1'b0) begin failures++; $display("FAIL rmid_rvalid got=%b%b exp=00", cpu_rvalid3, dma_rvalid3); end
    checks++; if (busy3 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b%b exp=00", busy3, busy1); end
    checks++; if (dma_gnt3 !== 1'b0) begin failures++; $display("FAIL rmid_gnt got=%b exp=0", dma_gnt3); end
    nextCycle();
    reset = 1'b1; dma_req = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
    @(negedge clk);
    checks++; if (cpu_gnt3 !== 1'b1 || dma_gnt3 !== 1'b0) begin failures++; $display("FAIL rmid_cpu_gnt got=%b%b exp=10", cpu_gnt3, dma_gnt3); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL rmid_unlocked got=%b exp=0", busy3); end
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      cpu_req = 1'b0; mem_rdata = 32'hE000_0000 + 32'(k);
      @(negedge clk);
      checks++; if (dma_rvalid3 !== 1'b0) begin failures++; $display("FAIL rmid_stale_dma k%0d got=%b exp=0", k, dma_rvalid3); end
      checks++; if (cpu_rvalid3 !== (k == 3)) begin failures++; $display("FAIL rmid_cpu_rvalid k%0d got=%b exp=%b", k, cpu_rvalid3, (k == 3)); end
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_last = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_starvation();
    test_burst3();
    test_max_burst();
    test_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
